// File: rtl/clock_out_ctrl.sv
// Sequencer for a forwarded-clock DDR output cell: it produces the rising/falling
// slot data pair per clk_in cycle, and supports a divided 50%-duty clock and finite bursts.
module clock_out_ctrl #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 16
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               en_req,
  input  logic [DIV_W-1:0]   div_cfg,
  input  logic [BURST_W-1:0] burst_len,
  output logic               ddr_h,
  output logic               ddr_l,
  output logic               running,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   c_reg, c_next;
  logic [DIV_W-1:0]   k_reg, k_next;
  logic [BURST_W-1:0] b_reg, b_next;
  logic [BURST_W-1:0] pcnt_reg, pcnt_next;
  logic               armed_reg, armed_next;
  logic               h_next, l_next, done_next;
  logic [BURST_W:0]   pcnt_inc;
  logic               boundary, burst_end;

  // pcnt_inc is one bit wider, so the burst-end compare also holds when pcnt is all-ones.
  assign pcnt_inc  = {1'b0, pcnt_reg} + (BURST_W+1)'(1);
  assign boundary  = (c_reg == k_reg);
  assign burst_end = (b_reg != '0) && (pcnt_inc == {1'b0, b_reg});

  always_comb begin
    state_next = state_reg;
    c_next     = c_reg;
    k_next     = k_reg;
    b_next     = b_reg;
    pcnt_next  = pcnt_reg;
    armed_next = armed_reg | ~en_req;
    done_next  = 1'b0;
    h_next     = 1'b0;
    l_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en_req && armed_reg) begin
          state_next = RUN;
          k_next     = div_cfg;
          b_next     = burst_len;
          c_next     = '0;
          pcnt_next  = '0;
        end
      end
      RUN: begin
        if (boundary) begin
          pcnt_next = (&pcnt_reg) ? pcnt_reg : pcnt_inc[BURST_W-1:0];
          k_next    = div_cfg;
          c_next    = '0;
          if (!en_req || burst_end) begin
            state_next = IDLE;
            done_next  = 1'b1;
            // A finished burst must see en_req low before it can start again.
            if (en_req) armed_next = 1'b0;
          end
        end else begin
          c_next = c_reg + DIV_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // Slots 2c and 2c+1 are high while the slot index is <= k. The compare is one bit wider, so it cannot overflow.
    if (state_next == RUN) begin
      h_next = ({c_next, 1'b0} <= {1'b0, k_next});
      l_next = ({c_next, 1'b1} <= {1'b0, k_next});
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      k_reg     <= '0;
      b_reg     <= '0;
      pcnt_reg  <= '0;
      armed_reg <= 1'b1;
      ddr_h     <= 1'b0;
      ddr_l     <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      c_reg     <= c_next;
      k_reg     <= k_next;
      b_reg     <= b_next;
      pcnt_reg  <= pcnt_next;
      armed_reg <= armed_next;
      ddr_h     <= h_next;
      ddr_l     <= l_next;
      running   <= (state_next == RUN);
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_clock_out_ctrl.sv
// Directed testbench for clock_out_ctrl. It compares {ddr_h,ddr_l,running,done}
// one time unit after each rising edge against hand-derived slot patterns.
module tb_clock_out_ctrl;
  localparam int DIV_W   = 8;
  localparam int BURST_W = 16;

  logic               clk_in = 1'b0;
  logic               rst_n;
  logic               en_req;
  logic [DIV_W-1:0]   div_cfg;
  logic [BURST_W-1:0] burst_len;
  logic               ddr_h, ddr_l, running, done;

  int checks = 0;
  int errors = 0;

  clock_out_ctrl #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en_req    (en_req),
    .div_cfg   (div_cfg),
    .burst_len (burst_len),
    .ddr_h     (ddr_h),
    .ddr_l     (ddr_l),
    .running   (running),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
    $display("t=%0t en=%b k=%0d h=%b l=%b run=%b done=%b",
             $time, en_req, div_cfg, ddr_h, ddr_l, running, done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_req = 1'b0; div_cfg = '0; burst_len = '0;
    #3;
    checks++;
    if ({ddr_h, ddr_l, running, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=0000", {ddr_h, ddr_l, running, done});
    end
    #9 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ddr_h, ddr_l, running, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle[%0d] got=%b exp=0000", i, {ddr_h, ddr_l, running, done});
      end
    end
  endtask

  task automatic test_passthrough();
    logic [3:0] exp_seq [8];
    for (int i = 0; i < 6; i++) exp_seq[i] = 4'b1010;
    exp_seq[6] = 4'b0001;
    exp_seq[7] = 4'b0000;
    div_cfg = 8'd0; burst_len = '0; en_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) en_req = 1'b0;
      tick();
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_seq[i]) begin
        errors++;
        $display("FAIL passthrough[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_seq[i]);
      end
    end
  endtask

  task automatic test_div2_continuous();
    logic [3:0] pat [3];
    logic [3:0] exp_v;
    pat[0] = 4'b1110; pat[1] = 4'b1010; pat[2] = 4'b0010;
    div_cfg = 8'd2; burst_len = '0; en_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 9) en_req = 1'b0;
      exp_v = (i < 9) ? pat[i % 3] : ((i == 9) ? 4'b0001 : 4'b0000);
      tick();
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_v) begin
        errors++;
        $display("FAIL div2[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_v);
      end
    end
  endtask

  task automatic test_stop_midperiod();
    logic [3:0] exp_seq [6];
    int done_cnt;
    exp_seq[0] = 4'b1110; exp_seq[1] = 4'b1110; exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0010; exp_seq[4] = 4'b0001; exp_seq[5] = 4'b0000;
    done_cnt = 0;
    div_cfg = 8'd3; burst_len = '0; en_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) en_req = 1'b0;
      tick();
      if (done) done_cnt++;
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_seq[i]) begin
        errors++;
        $display("FAIL stop_mid[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_seq[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL stop_mid_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_seq [16];
    logic       en_seq  [16];
    int done_cnt;
    // Burst of 3 periods at k=1; burst_len changes mid-burst must be ignored.
    for (int i = 0; i < 6; i++) begin
      exp_seq[i] = (i % 2 == 0) ? 4'b1110 : 4'b0010;
      en_seq[i] = 1'b1;
    end
    exp_seq[6]  = 4'b0001; en_seq[6]  = 1'b1;
    exp_seq[7]  = 4'b0000; en_seq[7]  = 1'b1;
    exp_seq[8]  = 4'b0000; en_seq[8]  = 1'b1;
    exp_seq[9]  = 4'b0000; en_seq[9]  = 1'b1;
    exp_seq[10] = 4'b0000; en_seq[10] = 1'b0;
    // Restart latches the new burst_len of 1.
    exp_seq[11] = 4'b1110; en_seq[11] = 1'b1;
    exp_seq[12] = 4'b0010; en_seq[12] = 1'b1;
    exp_seq[13] = 4'b0001; en_seq[13] = 1'b1;
    exp_seq[14] = 4'b0000; en_seq[14] = 1'b1;
    exp_seq[15] = 4'b0000; en_seq[15] = 1'b0;
    done_cnt = 0;
    div_cfg = 8'd1; burst_len = 16'd3;
    for (int i = 0; i < 16; i++) begin
      en_req = en_seq[i];
      if (i == 1) burst_len = 16'd1;
      tick();
      if (done && i < 10) done_cnt++;
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_seq[i]) begin
        errors++;
        $display("FAIL burst[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_seq[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL burst_done_count got=%0d exp=1", done_cnt);
    end
    burst_len = '0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_seq [5];
    logic       en_seq  [5];
    exp_seq[0] = 4'b1010; en_seq[0] = 1'b1;
    exp_seq[1] = 4'b0001; en_seq[1] = 1'b0;
    exp_seq[2] = 4'b0000; en_seq[2] = 1'b0;
    exp_seq[3] = 4'b1010; en_seq[3] = 1'b1;
    exp_seq[4] = 4'b0001; en_seq[4] = 1'b0;
    div_cfg = 8'd0; burst_len = 16'd1;
    for (int i = 0; i < 5; i++) begin
      en_req = en_seq[i];
      tick();
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_seq[i]) begin
        errors++;
        $display("FAIL simultaneous[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_seq[i]);
      end
    end
    burst_len = '0;
  endtask

  task automatic test_div_change();
    logic [3:0] exp_seq [12];
    exp_seq[0]  = 4'b1110; exp_seq[1]  = 4'b0010;
    exp_seq[2]  = 4'b1110; exp_seq[3]  = 4'b1110; exp_seq[4]  = 4'b0010; exp_seq[5]  = 4'b0010;
    exp_seq[6]  = 4'b1110; exp_seq[7]  = 4'b1110; exp_seq[8]  = 4'b0010; exp_seq[9]  = 4'b0010;
    exp_seq[10] = 4'b0001; exp_seq[11] = 4'b0000;
    div_cfg = 8'd1; burst_len = '0; en_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) div_cfg = 8'd3;
      if (i == 7) en_req = 1'b0;
      tick();
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_seq[i]) begin
        errors++;
        $display("FAIL div_change[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_seq [5];
    exp_seq[0] = 4'b1110; exp_seq[1] = 4'b1110; exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0010; exp_seq[4] = 4'b0001;
    div_cfg = 8'd3; burst_len = '0; en_req = 1'b1;
    tick();
    checks++;
    if ({ddr_h, ddr_l, running, done} !== 4'b1110) begin
      errors++;
      $display("FAIL async_pre got=%b exp=1110", {ddr_h, ddr_l, running, done});
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ddr_h, ddr_l, running, done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b exp=0000", {ddr_h, ddr_l, running, done});
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) en_req = 1'b0;
      tick();
      checks++;
      if ({ddr_h, ddr_l, running, done} !== exp_seq[i]) begin
        errors++;
        $display("FAIL async_restart[%0d] got=%b exp=%b", i, {ddr_h, ddr_l, running, done}, exp_seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_div2_continuous();
    test_stop_midperiod();
    test_burst();
    test_simultaneous();
    test_div_change();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
